adder4_seq_ctrl: RTL and testbench

//   Sequencing controller that reuses one adder4 instance (ports A,B,CI,SUM,CO)
//   to add two NIBBLES*4-bit operands over NIBBLES cycles, LS nibble first.
//   The carry chains between nibbles through a register.

---
 rtl/adder4_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_adder4_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder4_seq_ctrl.sv
// Sequential multi-nibble adder that time-shares one 4-bit adder, LS nibble first.
// Optional signed-overflow output is enabled by defining ADDER_OVF_EN.

module adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [3:0] SUM,
  output logic       CO
);
  assign {CO, SUM} = 5'(A) + 5'(B) + 5'(CI);
endmodule

module adder4_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   CI,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   SUM,
  output logic                   CO
`ifdef ADDER_OVF_EN
  ,
  output logic                   OVF
`endif
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             c_q;
  logic [W-1:0]     work_q;
  logic [W-1:0]     work_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     sum_q;
  logic             co_q;
  logic             last_c;

  logic [3:0]       a_nib_c;
  logic [3:0]       b_nib_c;
  logic [3:0]       add_sum_c;
  logic             add_co_c;

  adder4 u_adder4 (
    .A   (a_nib_c),
    .B   (b_nib_c),
    .CI  (c_q),
    .SUM (add_sum_c),
    .CO  (add_co_c)
  );

  // Select the current operand nibbles and merge the adder result into the work value.
  always_comb begin
    a_nib_c = 4'h0;
    b_nib_c = 4'h0;
    work_d  = work_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib_c            = a_q[4*i +: 4];
        b_nib_c            = b_q[4*i +: 4];
        work_d[4*i +: 4]   = add_sum_c;
      end
    end
  end

  assign last_c = (idx_q == IDX_W'(NIBBLES - 1));

`ifdef ADDER_OVF_EN
  logic ovf_q;
  assign OVF = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      co_q        <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            c_q        <= CI;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_ADD;
          end
        end
        ST_ADD: begin
          work_q <= work_d;
          c_q    <= add_co_c;
          idx_q  <= idx_q + IDX_W'(1);
          // Result registers update only here, so partial sums never reach SUM.
          if (last_c) begin
            sum_q       <= work_d;
            co_q        <= add_co_c;
`ifdef ADDER_OVF_EN
            ovf_q       <= (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
`endif
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign SUM       = sum_q;
  assign CO        = co_q;

endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Scoreboard bench for adder4_seq_ctrl (NIBBLES=4); overflow checks when ADDER_OVF_EN is defined.

module tb_adder4_seq_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CI;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] SUM;
  logic         CO;
  logic         OVF;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adder4_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CI        (CI),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (SUM),
    .CO        (CO)
`ifdef ADDER_OVF_EN
    ,
    .OVF       (OVF)
`endif
  );

`ifndef ADDER_OVF_EN
  assign OVF = 1'b0;
`endif

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] t;
    exp_t       r;
    t     = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    r.sum = t[W-1:0];
    r.co  = t[W];
    r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Starts and ends on a negedge with the DUT idle; out_ready assumed high.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input string name);
    exp_t e;
    int   n;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready: in_ready got %b exp 1", name, in_ready); end
    in_valid = 1'b1; A = a; B = b; CI = ci;
    sb_q.push_back(model(a, b, ci));
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s busy_ready: in_ready got %b exp 0", name, in_ready); end
    wait_valid(n);
    checks++;
    if (n != int'(NIB)) begin errors++; $display("FAIL %s latency: got %0d exp %0d", name, n, NIB); end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s scoreboard: queue empty", name);
    end else begin
      e = sb_q.pop_front();
      if (SUM !== e.sum || CO !== e.co) begin
        errors++; $display("FAIL %s result: SUM/CO got %h/%b exp %h/%b", name, SUM, CO, e.sum, e.co);
      end
`ifdef ADDER_OVF_EN
      checks++;
      if (OVF !== e.ovf) begin errors++; $display("FAIL %s ovf: got %b exp %b", name, OVF, e.ovf); end
`endif
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release: out_valid/in_ready got %b/%b exp 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; CI = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || SUM !== '0 || CO !== 1'b0 || OVF !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy/vld/SUM/CO/OVF got %b/%b/%h/%b/%b exp 1/0/0000/0/0",
               in_ready, out_valid, SUM, CO, OVF);
    end
  endtask

  task automatic test_basic();
    run_job(16'h0000, 16'h0000, 1'b0, "zero");
    run_job(16'hFFFF, 16'h0001, 1'b0, "ripple");
    run_job(16'h1234, 16'h4321, 1'b1, "cin");
    run_job(16'h8888, 16'h8888, 1'b0, "wrap");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    out_ready = 1'b0;
    in_valid = 1'b1; A = 16'h0F0F; B = 16'h00F1; CI = 1'b1;
    sb_q.push_back(model(16'h0F0F, 16'h00F1, 1'b1));
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; CI = 1'b0;
    wait_valid(n);
    checks++;
    if (n != int'(NIB)) begin errors++; $display("FAIL bp latency: got %0d exp %0d", n, NIB); end
    e = sb_q.pop_front();
    checks++;
    if (SUM !== e.sum || CO !== e.co) begin
      errors++; $display("FAIL bp result: SUM/CO got %h/%b exp %h/%b", SUM, CO, e.sum, e.co);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || SUM !== e.sum || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp hold%0d: vld/SUM/rdy got %b/%h/%b exp 1/%h/0", i, out_valid, SUM, in_ready, e.sum);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp release: vld/rdy got %b/%b exp 0/1", out_valid, in_ready);
    end
    repeat (NIB + 2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || SUM !== e.sum || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp ignored: vld/SUM/rdy got %b/%h/%b exp 0/%h/1", out_valid, SUM, in_ready, e.sum);
    end
  endtask

  task automatic test_reset_mid_add();
    int seen;
    in_valid = 1'b1; A = 16'hFFFF; B = 16'h0001; CI = 1'b0;
    sb_q.push_back(model(16'hFFFF, 16'h0001, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || SUM !== '0 || CO !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: rdy/vld/SUM/CO got %b/%b/%h/%b exp 1/0/0000/0", in_ready, out_valid, SUM, CO);
    end
    seen = 0;
    repeat (NIB + 2) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_mid discard: out_valid cycles got %0d exp 0", seen); end
    run_job(16'h0F0F, 16'h0101, 1'b0, "after_rst");
  endtask

  task automatic test_rst_vs_valid();
    int seen;
    rst = 1'b1; in_valid = 1'b1; A = 16'h5555; B = 16'h5555; CI = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (NIB + 3) begin
      @(negedge clk);
      if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_wins: busy cycles got %0d exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_job(W'($urandom), W'($urandom), 1'($urandom), "b2b");
    end
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    run_job(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    run_job(16'h8000, 16'h8000, 1'b0, "ovf_neg");
    run_job(16'h1234, 16'h4321, 1'b0, "ovf_none");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_add();
    test_rst_vs_valid();
    test_back_to_back();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
